// File: rtl/avr_cpu_stack_ctrl.sv
// AVR call/return stack controller: splits 18-bit return addresses into two
// 9-bit words on the shared stack bus, with CALL/IRQ push and RET/RETI pop.
module avr_cpu_stack_ctrl #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         call_req,
  input  logic [17:0]                  call_addr,
  input  logic                         irq_req,
  input  logic [17:0]                  irq_addr,
  input  logic                         ret_req,
  output logic                         call_ack,
  output logic                         irq_ack,
  output logic                         ret_ack,
  output logic [17:0]                  ret_addr,
  output logic                         stack_write,
  output logic                         stack_read,
  output logic                         stack_oe,
  output logic [8:0]                   stack_dout,
  input  logic [8:0]                   stack_din,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  localparam int unsigned LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LVL_PUSH_MAX = LW'(DEPTH - 2);
  localparam logic [LW-1:0] LVL_POP_MIN  = LW'(2);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_DONE
  } state_t;

  state_t        state;
  logic [17:0]   push_addr;
  logic          push_is_irq;
  logic [8:0]    ret_lo;
  logic [8:0]    ret_hi;
  logic [LW-1:0] level_q;
  logic          write_q;
  logic          read_q;
  logic [8:0]    dout_q;
  logic          call_ack_q;
  logic          irq_ack_q;
  logic          ret_ack_q;

  logic          idle_ok;
  logic          grant_irq;
  logic          grant_ret;
  logic          grant_call;
  logic          push_full;
  logic          pop_empty;
  logic          ovf;
  logic          unf;
  logic [17:0]   sel_addr;

  // Refused requests are answered combinationally in the grant cycle, so the
  // grant decode is gated by rst_n to keep every output quiet during reset.
  always_comb begin
    idle_ok    = rst_n && (state == IDLE);
    grant_irq  = idle_ok && irq_req;
    grant_ret  = idle_ok && !irq_req && ret_req;
    grant_call = idle_ok && !irq_req && !ret_req && call_req;
    push_full  = level_q > LVL_PUSH_MAX;
    pop_empty  = level_q < LVL_POP_MIN;
    ovf        = (grant_irq || grant_call) && push_full;
    unf        = grant_ret && pop_empty;
    sel_addr   = grant_irq ? irq_addr : call_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      push_addr   <= '0;
      push_is_irq <= 1'b0;
      ret_lo      <= '0;
      ret_hi      <= '0;
      level_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      dout_q      <= '0;
      call_ack_q  <= 1'b0;
      irq_ack_q   <= 1'b0;
      ret_ack_q   <= 1'b0;
    end else begin
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      dout_q     <= '0;
      call_ack_q <= 1'b0;
      irq_ack_q  <= 1'b0;
      ret_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          if ((grant_irq || grant_call) && !push_full) begin
            push_addr   <= sel_addr;
            push_is_irq <= grant_irq;
            write_q     <= 1'b1;
            dout_q      <= sel_addr[17:9];
            state       <= PUSH_HI;
          end else if (grant_ret && !pop_empty) begin
            ret_lo <= '0;
            ret_hi <= '0;
            read_q <= 1'b1;
            state  <= POP_LO;
          end
        end
        PUSH_HI: begin
          level_q    <= level_q + LW'(1);
          write_q    <= 1'b1;
          dout_q     <= push_addr[8:0];
          call_ack_q <= !push_is_irq;
          irq_ack_q  <= push_is_irq;
          state      <= PUSH_LO;
        end
        PUSH_LO: begin
          level_q <= level_q + LW'(1);
          state   <= IDLE;
        end
        POP_LO: begin
          level_q <= level_q - LW'(1);
          read_q  <= 1'b1;
          state   <= POP_HI;
        end
        POP_HI: begin
          level_q   <= level_q - LW'(1);
          ret_lo    <= stack_din;
          ret_ack_q <= 1'b1;
          state     <= POP_DONE;
        end
        POP_DONE: begin
          ret_hi <= stack_din;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // High word arrives on the bus during POP_DONE itself, so it is forwarded
  // straight through while ret_ack is up and held in ret_hi afterwards.
  always_comb begin
    ret_addr = {ret_hi, ret_lo};
    if (state == POP_DONE) ret_addr[17:9] = stack_din;
    if (unf) ret_addr = '0;
  end

  assign call_ack      = call_ack_q | (grant_call && push_full);
  assign irq_ack       = irq_ack_q  | (grant_irq && push_full);
  assign ret_ack       = ret_ack_q  | unf;
  assign err_overflow  = ovf;
  assign err_underflow = unf;
  assign stack_write   = write_q;
  assign stack_oe      = write_q;
  assign stack_read    = read_q;
  assign stack_dout    = dout_q;
  assign level         = level_q;

endmodule
